alarm_tone_apb: RTL and testbench

ALARM_TONE_APB -- requirements
Module: alarm_tone_apb

---
 rtl/alarm_tone_pkg.sv | 39 +++
 rtl/alarm_tone_ch.sv | 76 +++++++
 rtl/alarm_tone_apb.sv | 198 +++++++++++++++++++
 tb/tb_alarm_tone_apb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_tone_pkg.sv
// Shared register map, field indices and address-decode enum for the alarm tone block.
// Optional IRQ support is selected with the ALARM_TONE_IRQ_EN macro.
package alarm_tone_pkg;

  localparam logic [31:0] OFS_CTRL     = 32'h00;
  localparam logic [31:0] OFS_STATUS   = 32'h04;
  localparam logic [31:0] OFS_START    = 32'h08;
  localparam logic [31:0] OFS_IRQ_MASK = 32'h0C;
  localparam logic [31:0] OFS_CH_BASE  = 32'h10;
  localparam int unsigned CH_STRIDE    = 8;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_SRST_BIT   = 1;
  localparam int unsigned STATUS_BUSY_LSB = 0;
  localparam int unsigned STATUS_DONE_LSB = 8;

  localparam int unsigned DUR_W = 16;

  typedef enum logic [2:0] {
    DEC_NONE,
    DEC_CTRL,
    DEC_STATUS,
    DEC_START,
    DEC_IRQ_MASK,
    DEC_HALF,
    DEC_DUR
  } dec_e;

  // Byte-lane write merge: lanes with strb clear keep the old value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
    return (old_val & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/alarm_tone_ch.sv
// One tone channel: half-period counter driving a square wave, plus a duration
// counter that ends the tone and latches a W1C done flag.
module alarm_tone_ch
  import alarm_tone_pkg::*;
#(
  parameter int unsigned CNT_W = 20
) (
  input  logic             pclk_i,
  input  logic             presetn_i,
  input  logic             en,
  input  logic             srst,
  input  logic             start,
  input  logic             done_clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] half,
  input  logic [DUR_W-1:0] dur,
  output logic             busy,
  output logic             done,
  output logic             square
);

  localparam int unsigned CW1 = CNT_W + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [DUR_W-1:0] dur_cnt_q;
  logic             wrap_c;
  logic             expire_c;
  logic             degen_c;
  logic             done_set_c;

  // ">=" rather than "==" so a HALF shrunk below the running count wraps at once.
  always_comb begin
    wrap_c     = (CW1'(cnt_q) + CW1'(1)) >= CW1'(half);
    expire_c   = busy && en && tick && (dur_cnt_q == DUR_W'(1));
    degen_c    = (half == '0) || (dur == '0);
    done_set_c = start ? degen_c : expire_c;
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      square    <= 1'b0;
      cnt_q     <= '0;
      dur_cnt_q <= '0;
    end else if (srst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      square    <= 1'b0;
      cnt_q     <= '0;
      dur_cnt_q <= '0;
    end else begin
      done <= done_set_c | (done & ~done_clr);
      if (start) begin
        busy      <= ~degen_c;
        square    <= 1'b0;
        cnt_q     <= '0;
        dur_cnt_q <= dur;
      end else if (expire_c) begin
        busy      <= 1'b0;
        square    <= 1'b0;
        cnt_q     <= '0;
        dur_cnt_q <= '0;
      end else if (busy && en) begin
        if (tick) dur_cnt_q <= dur_cnt_q - DUR_W'(1);
        if (wrap_c) begin
          cnt_q  <= '0;
          square <= ~square;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/alarm_tone_apb.sv
// APB-controlled multi-channel alarm tone generator mixing square waves onto aud_pwm.
// Define ALARM_TONE_IRQ_EN to add irq_o and the IRQ_MASK register at 0x0C.
module alarm_tone_apb
  import alarm_tone_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 20,
  parameter int unsigned PRESC  = 100000
) (
  input  logic        pclk_i,
  input  logic        presetn_i,
  input  logic [31:0] paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o,
  output logic        aud_pwm
`ifdef ALARM_TONE_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [31:0] CH_END  = OFS_CH_BASE + 32'(CH_STRIDE * NUM_CH);

  logic               en_q;
  logic [PRESC_W-1:0] presc_q;
  logic               tick_c;
  logic [CNT_W-1:0]   half_q [NUM_CH];
  logic [DUR_W-1:0]   dur_q  [NUM_CH];
  logic [NUM_CH-1:0]  busy;
  logic [NUM_CH-1:0]  done;
  logic [NUM_CH-1:0]  square;
  logic [NUM_CH-1:0]  start_c;
  logic [NUM_CH-1:0]  done_clr_c;
`ifdef ALARM_TONE_IRQ_EN
  logic [NUM_CH-1:0]  irq_mask_q;
`endif

  dec_e               dec_c;
  logic [CH_W-1:0]    dec_ch_c;
  logic               err_c;
  logic               setup_c;
  logic               wr_ok_c;
  logic               srst_c;
  logic [31:0]        rdata_c;

  assign pready_o = 1'b1;

  // Address decode; misaligned addresses never match and fall through to DEC_NONE.
  always_comb begin
    dec_c    = DEC_NONE;
    dec_ch_c = '0;
    if (paddr_i == OFS_CTRL) begin
      dec_c = DEC_CTRL;
    end else if (paddr_i == OFS_STATUS) begin
      dec_c = DEC_STATUS;
    end else if (paddr_i == OFS_START) begin
      dec_c = DEC_START;
`ifdef ALARM_TONE_IRQ_EN
    end else if (paddr_i == OFS_IRQ_MASK) begin
      dec_c = DEC_IRQ_MASK;
`endif
    end else if ((paddr_i[1:0] == 2'b00) && (paddr_i >= OFS_CH_BASE) && (paddr_i < CH_END)) begin
      dec_c    = paddr_i[2] ? DEC_DUR : DEC_HALF;
      dec_ch_c = CH_W'((paddr_i - OFS_CH_BASE) >> 3);
    end
  end

  always_comb begin
    err_c   = (dec_c == DEC_NONE) ||
              (pwrite_i && (dec_c == DEC_STATUS) && pstrb_i[0] &&
               (pwdata_i[STATUS_BUSY_LSB +: NUM_CH] != '0));
    setup_c = psel_i && !penable_i;
    wr_ok_c = psel_i && penable_i && pwrite_i && !err_c;
    srst_c  = wr_ok_c && (dec_c == DEC_CTRL) && pstrb_i[0] && pwdata_i[CTRL_SRST_BIT];
  end

  always_comb begin
    start_c    = '0;
    done_clr_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      start_c[i]    = wr_ok_c && (dec_c == DEC_START) && pstrb_i[0] && pwdata_i[i];
      done_clr_c[i] = wr_ok_c && (dec_c == DEC_STATUS) && pstrb_i[1] &&
                      pwdata_i[STATUS_DONE_LSB + i];
    end
  end

  always_comb begin
    rdata_c = '0;
    case (dec_c)
      DEC_CTRL:     rdata_c[CTRL_EN_BIT] = en_q;
      DEC_STATUS: begin
        rdata_c[STATUS_BUSY_LSB +: NUM_CH] = busy;
        rdata_c[STATUS_DONE_LSB +: NUM_CH] = done;
      end
      DEC_HALF:     rdata_c = 32'(half_q[dec_ch_c]);
      DEC_DUR:      rdata_c = 32'(dur_q[dec_ch_c]);
`ifdef ALARM_TONE_IRQ_EN
      DEC_IRQ_MASK: rdata_c = 32'(irq_mask_q);
`endif
      default:      rdata_c = '0;
    endcase
  end

  // Configuration registers; SRST deliberately leaves these untouched.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      en_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        half_q[i] <= '0;
        dur_q[i]  <= '0;
      end
`ifdef ALARM_TONE_IRQ_EN
      irq_mask_q <= '0;
`endif
    end else if (wr_ok_c) begin
      case (dec_c)
        DEC_CTRL: if (pstrb_i[0]) en_q <= pwdata_i[CTRL_EN_BIT];
        DEC_HALF: half_q[dec_ch_c] <= CNT_W'(lane_merge(32'(half_q[dec_ch_c]), pwdata_i, pstrb_i));
        DEC_DUR:  dur_q[dec_ch_c]  <= DUR_W'(lane_merge(32'(dur_q[dec_ch_c]), pwdata_i, pstrb_i));
`ifdef ALARM_TONE_IRQ_EN
        DEC_IRQ_MASK: if (pstrb_i[0]) irq_mask_q <= pwdata_i[NUM_CH-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Response captured in the setup phase so it is already valid during the access phase.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      prdata_o  <= '0;
      pslverr_o <= 1'b0;
    end else begin
      pslverr_o <= setup_c && err_c;
      prdata_o  <= (setup_c && !pwrite_i && !err_c) ? rdata_c : '0;
    end
  end

  assign tick_c = en_q && (presc_q == PRESC_W'(PRESC - 1));

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      presc_q <= '0;
    end else if (srst_c) begin
      presc_q <= '0;
    end else if (en_q) begin
      presc_q <= tick_c ? '0 : presc_q + PRESC_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    alarm_tone_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .pclk_i    (pclk_i),
      .presetn_i (presetn_i),
      .en        (en_q),
      .srst      (srst_c),
      .start     (start_c[g]),
      .done_clr  (done_clr_c[g]),
      .tick      (tick_c),
      .half      (half_q[g]),
      .dur       (dur_q[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .square    (square[g])
    );
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      aud_pwm <= 1'b0;
    end else if (srst_c) begin
      aud_pwm <= 1'b0;
    end else begin
      aud_pwm <= en_q && |(square & busy);
    end
  end

`ifdef ALARM_TONE_IRQ_EN
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |(done & irq_mask_q);
    end
  end
`endif

endmodule

// File: tb/tb_alarm_tone_apb.sv
// Scoreboard bench for alarm_tone_apb: APB responses are queued by the driver and
// compared by a monitor at each access phase; tone timing is checked directly.
module tb_alarm_tone_apb;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 20;
  localparam int unsigned PRESC  = 10;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_START  = 32'h08;
  localparam logic [31:0] A_IRQM   = 32'h0C;
  localparam logic [31:0] A_HALF0  = 32'h10;
  localparam logic [31:0] A_DUR0   = 32'h14;
  localparam logic [31:0] A_HALF1  = 32'h18;
  localparam logic [31:0] A_DUR1   = 32'h1C;
  localparam logic [31:0] ST_MASK  = 32'h0000_0F0F;

  logic        pclk_i    = 1'b0;
  logic        presetn_i = 1'b0;
  logic [31:0] paddr_i   = '0;
  logic        psel_i    = 1'b0;
  logic        penable_i = 1'b0;
  logic        pwrite_i  = 1'b0;
  logic [31:0] pwdata_i  = '0;
  logic [3:0]  pstrb_i   = '0;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;
  logic        aud_pwm;
`ifdef ALARM_TONE_IRQ_EN
  logic        irq_o;
`endif

  alarm_tone_apb #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PRESC  (PRESC)
  ) dut (
    .pclk_i    (pclk_i),
    .presetn_i (presetn_i),
    .paddr_i   (paddr_i),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .pwdata_i  (pwdata_i),
    .pstrb_i   (pstrb_i),
    .pready_o  (pready_o),
    .prdata_o  (prdata_o),
    .pslverr_o (pslverr_o),
    .aud_pwm   (aud_pwm)
`ifdef ALARM_TONE_IRQ_EN
    ,
    .irq_o     (irq_o)
`endif
  );

  always #5 pclk_i = ~pclk_i;

  int cyc = 0;
  always @(posedge pclk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        err;
    bit          chk;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d cycles, required %0d..%0d", nm, act, lo, hi);
  endtask

  // Monitor: every access phase pops one expectation.
  always @(negedge pclk_i) begin
    if (psel_i && penable_i) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: transfer at 0x%08h, required a queued expectation", paddr_i);
      end else begin
        mon_e      = sb_q.pop_front();
        last_rdata = prdata_o;
        if (mon_e.chk) begin
          check({mon_e.name, "_err"}, 32'(pslverr_o), 32'(mon_e.err));
          if (mon_e.mask != '0)
            check({mon_e.name, "_data"}, prdata_o & mon_e.mask, mon_e.data & mon_e.mask);
        end
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    @(posedge pclk_i); #1;
    paddr_i = a; pwrite_i = w; pwdata_i = d; pstrb_i = s; psel_i = 1'b1; penable_i = 1'b0;
    @(posedge pclk_i); #1;
    penable_i = 1'b1;
    @(posedge pclk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] m, input logic e, input bit c, input string nm);
    exp_t x;
    x.data = d; x.mask = m; x.err = e; x.chk = c; x.name = nm;
    sb_q.push_back(x);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic err, input string nm);
    push('0, '0, err, 1'b1, nm);
    xfer(a, 1'b1, d, s);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic [31:0] m, input string nm);
    push(exp, m, 1'b0, 1'b1, nm);
    xfer(a, 1'b0, '0, 4'h0);
  endtask

  task automatic rd_err(input logic [31:0] a, input string nm);
    push('0, '0, 1'b1, 1'b1, nm);
    xfer(a, 1'b0, '0, 4'h0);
  endtask

  task automatic peek(input logic [31:0] a);
    push('0, '0, 1'b0, 1'b0, "peek");
    xfer(a, 1'b0, '0, 4'h0);
  endtask

  // Poll STATUS until bit b equals want; elapsed is 9999 if the budget runs out.
  task automatic poll_bit(input int b, input logic want, input int t_start, output int el);
    el = 9999;
    for (int k = 0; k < 20; k++) begin
      if (el == 9999) begin
        peek(A_STATUS);
        if (last_rdata[b] == want) el = cyc - t_start;
      end
    end
  endtask

  int   t0;
  int   el;
  int   rise1, fall1, rise2, hi_cnt;
  logic prev;

  initial begin
    repeat (3) @(posedge pclk_i);
    check("aud_in_reset", 32'(aud_pwm), 32'h0);
    #1 presetn_i = 1'b1;

    // Reset state
    check("pready_high", 32'(pready_o), 32'h1);
    check("pslverr_reset", 32'(pslverr_o), 32'h0);
    check("prdata_reset", prdata_o, 32'h0);
    check("aud_reset", 32'(aud_pwm), 32'h0);
    rd(A_CTRL,   32'h0, 32'hFFFF_FFFF, "rst_ctrl");
    rd(A_STATUS, 32'h0, 32'hFFFF_FFFF, "rst_status");
    rd(A_START,  32'h0, 32'hFFFF_FFFF, "rst_start");
    for (int c = 0; c < NUM_CH; c++) begin
      rd(A_HALF0 + 32'(8*c), 32'h0, 32'hFFFF_FFFF, $sformatf("rst_half%0d", c));
      rd(A_DUR0  + 32'(8*c), 32'h0, 32'hFFFF_FFFF, $sformatf("rst_dur%0d", c));
    end
`ifdef ALARM_TONE_IRQ_EN
    rd(A_IRQM, 32'h0, 32'hFFFF_FFFF, "rst_irqmask");
    check("irq_reset", 32'(irq_o), 32'h0);
`endif

    // Configure channel 0 and enable
    wr(A_HALF0, 32'd5, 4'hF, 1'b0, "wr_half0");
    wr(A_DUR0,  32'd3, 4'hF, 1'b0, "wr_dur0");
    wr(A_CTRL,  32'h1, 4'hF, 1'b0, "wr_ctrl_en");
    rd(A_HALF0, 32'd5, 32'hFFFF_FFFF, "rb_half0");
    rd(A_DUR0,  32'd3, 32'hFFFF_FFFF, "rb_dur0");
    rd(A_CTRL,  32'h1, 32'hFFFF_FFFF, "rb_ctrl");
`ifdef ALARM_TONE_IRQ_EN
    wr(A_IRQM, 32'h1, 4'hF, 1'b0, "wr_irqmask");
`endif

    // Single tone: square toggles every 5 clocks, aud follows one clock later
    wr(A_START, 32'h1, 4'hF, 1'b0, "start0");
    t0 = cyc;
    rise1 = -1; fall1 = -1; rise2 = -1; prev = aud_pwm;
    for (int j = 0; j < 20; j++) begin
      @(negedge pclk_i);
      if (aud_pwm && !prev) begin
        if (rise1 < 0) rise1 = j;
        else if (rise2 < 0) rise2 = j;
      end
      if (!aud_pwm && prev && fall1 < 0) fall1 = j;
      prev = aud_pwm;
    end
    check("tone_first_rise", 32'(rise1), 32'd6);
    check("tone_high_time", 32'(fall1 - rise1), 32'd5);
    check("tone_low_time", 32'(rise2 - fall1), 32'd5);
    poll_bit(0, 1'b0, t0, el);
    check_range("done0_time", el, 20, 40);
    rd(A_STATUS, 32'h100, ST_MASK, "status_done0");
    check("aud_after_done", 32'(aud_pwm), 32'h0);
`ifdef ALARM_TONE_IRQ_EN
    check("irq_on_done", 32'(irq_o), 32'h1);
`endif
    wr(A_STATUS, 32'h100, 4'b0010, 1'b0, "w1c_done0");
    rd(A_STATUS, 32'h0, ST_MASK, "status_cleared");
`ifdef ALARM_TONE_IRQ_EN
    check("irq_after_w1c", 32'(irq_o), 32'h0);
`endif

    // Error responses leave state unchanged
    wr(32'h40, 32'hFF, 4'hF, 1'b1, "err_unmapped");
    rd_err(32'h02, "err_misaligned");
    wr(A_STATUS, 32'h1, 4'hF, 1'b1, "err_ro_busy");
`ifndef ALARM_TONE_IRQ_EN
    rd_err(A_IRQM, "err_irq_absent");
`endif
    wr(A_CTRL, 32'h0, 4'b0000, 1'b0, "ctrl_nostrb");
    rd(A_CTRL, 32'h1, 32'hFFFF_FFFF, "ctrl_kept");
    rd(A_STATUS, 32'h0, ST_MASK, "status_kept");
    rd(A_HALF0, 32'd5, 32'hFFFF_FFFF, "half0_kept");

    // Byte-lane write
    wr(A_HALF1, 32'h00AB_CDEF, 4'b0010, 1'b0, "half1_lane1");
    rd(A_HALF1, 32'h0000_CD00, 32'hFFFF_FFFF, "half1_lane_rb");
    wr(A_HALF1, 32'h0, 4'hF, 1'b0, "half1_zero");

    // Degenerate start: HALF1 == 0
    wr(A_DUR1, 32'd2, 4'hF, 1'b0, "wr_dur1");
    wr(A_START, 32'h2, 4'hF, 1'b0, "start1_degen");
    rd(A_STATUS, 32'h200, ST_MASK, "degen_ch1");
    wr(A_STATUS, 32'h200, 4'b0010, 1'b0, "w1c_done1");

    // Restart mid-tone reloads the duration, DONE untouched
    wr(A_START, 32'h1, 4'hF, 1'b0, "start0_b");
    repeat (15) @(posedge pclk_i);
    wr(A_START, 32'h1, 4'hF, 1'b0, "restart0");
    t0 = cyc;
    rd(A_STATUS, 32'h001, ST_MASK, "restart_busy");
    poll_bit(0, 1'b0, t0, el);
    check_range("restart_done_time", el, 20, 40);
    rd(A_STATUS, 32'h100, ST_MASK, "restart_done");
    wr(A_STATUS, 32'h100, 4'b0010, 1'b0, "w1c_done0_b");

    // Pause with EN=0, then resume
    wr(A_START, 32'h1, 4'hF, 1'b0, "start0_c");
    repeat (12) @(posedge pclk_i);
    wr(A_CTRL, 32'h0, 4'hF, 1'b0, "pause");
    repeat (3) @(posedge pclk_i);
    hi_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge pclk_i);
      if (aud_pwm) hi_cnt++;
    end
    check("pause_aud_low", 32'(hi_cnt), 32'h0);
    rd(A_STATUS, 32'h001, ST_MASK, "pause_busy_held");
    wr(A_CTRL, 32'h1, 4'hF, 1'b0, "resume");
    t0 = cyc;
    poll_bit(0, 1'b0, t0, el);
    check_range("resume_done_time", el, 1, 30);
    rd(A_STATUS, 32'h100, ST_MASK, "resume_done");
    wr(A_STATUS, 32'h100, 4'b0010, 1'b0, "w1c_done0_c");

    // Soft reset keeps EN and HALF
    wr(A_START, 32'h1, 4'hF, 1'b0, "start0_d");
    repeat (8) @(posedge pclk_i);
    wr(A_CTRL, 32'h3, 4'hF, 1'b0, "srst");
    rd(A_STATUS, 32'h0, ST_MASK, "srst_status");
    rd(A_CTRL, 32'h1, 32'hFFFF_FFFF, "srst_ctrl");
    rd(A_HALF0, 32'd5, 32'hFFFF_FFFF, "srst_half0");
    check("srst_aud", 32'(aud_pwm), 32'h0);

    // Hard reset mid-tone aborts without DONE
    wr(A_START, 32'h1, 4'hF, 1'b0, "start0_e");
    repeat (8) @(posedge pclk_i);
    #1 check("tone_pre_reset", 32'(aud_pwm), 32'h1);
    presetn_i = 1'b0;
    #1 check("reset_async_aud", 32'(aud_pwm), 32'h0);
    @(posedge pclk_i); #1 presetn_i = 1'b1;
    rd(A_STATUS, 32'h0, 32'hFFFF_FFFF, "reset_abort_status");
    rd(A_CTRL, 32'h0, 32'hFFFF_FFFF, "reset_ctrl");
    rd(A_HALF0, 32'h0, 32'hFFFF_FFFF, "reset_half0");

    repeat (2) @(posedge pclk_i);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
